// File: rtl/top_pkg.sv
// Shared types and default parameter values for the Q-seek controller.
package top_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEAS,
        UPDATE
    } ctrl_state_t;

    localparam int DEF_BUS_WIDTH         = 10;
    localparam int DEF_WTD_BUS_WIDTH     = 3;
    localparam int DEF_Q_PER_PULSE       = 3;
    localparam int DEF_TOL               = 6;
    localparam int DEF_I_REF_DELTA_INSTB = 10;
    localparam int DEF_DELTA_Q_INSTB     = 50;
    localparam int DEF_INCLUDE_Q_DROP    = 0;

endpackage

// File: rtl/q_control.sv
// Control loop for the Q seek: sequencing FSM, error-proportional i_ref stepping,
// saturation, optional Q-collapse back-off with a sticky ceiling, and the converged flag.
module q_control
    import top_pkg::*;
#(
    parameter int BUS_WIDTH         = DEF_BUS_WIDTH,
    parameter int TOL               = DEF_TOL,
    parameter int I_REF_DELTA_INSTB = DEF_I_REF_DELTA_INSTB,
    parameter int DELTA_Q_INSTB     = DEF_DELTA_Q_INSTB,
    parameter int INCLUDE_Q_DROP    = DEF_INCLUDE_Q_DROP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 enable,
    input  logic                 ready,
    input  logic [BUS_WIDTH-1:0] q_desired,
    input  logic [BUS_WIDTH-1:0] q_measured,
    output logic [BUS_WIDTH-1:0] i_ref,
    output logic                 converged
);

    localparam int EW = BUS_WIDTH + 1;

    ctrl_state_t state, state_next;

    logic signed [EW-1:0] err;
    logic [EW-1:0]        err_abs;
    logic [EW-1:0]        quarter;
    logic [BUS_WIDTH-1:0] step;
    logic                 in_tol;
    logic                 do_update;
    logic [BUS_WIDTH:0]   up_sum;
    logic [BUS_WIDTH-1:0] up_val;
    logic [BUS_WIDTH-1:0] down_val;
    logic [BUS_WIDTH-1:0] backoff_val;
    logic [BUS_WIDTH-1:0] ceiling;
    logic [BUS_WIDTH-1:0] prev_q;
    logic                 last_raised;
    logic                 drop_hit;
    logic                 unstable;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start && enable) state_next = WAIT_MEAS;
            WAIT_MEAS: if (ready) state_next = UPDATE;
            UPDATE:    state_next = WAIT_MEAS;
            default:   state_next = IDLE;
        endcase
        if (!start || !enable) begin
            state_next = IDLE;
        end
    end

    assign do_update = (state == UPDATE) && start && enable;

    assign err     = $signed({1'b0, q_desired}) - $signed({1'b0, q_measured});
    assign err_abs = err[EW-1] ? EW'(-err) : EW'(err);
    assign quarter = err_abs >> 2;
    assign step    = (quarter == '0) ? BUS_WIDTH'(1) : quarter[BUS_WIDTH-1:0];
    assign in_tol  = (err_abs <= EW'(TOL));

    // The ceiling is all-ones until a collapse is seen, so it doubles as the natural saturation point
    assign up_sum      = {1'b0, i_ref} + {1'b0, step};
    assign up_val      = (up_sum > {1'b0, ceiling}) ? ceiling : up_sum[BUS_WIDTH-1:0];
    assign down_val    = (i_ref > step) ? (i_ref - step) : '0;
    assign backoff_val = (i_ref > BUS_WIDTH'(I_REF_DELTA_INSTB)) ?
                         (i_ref - BUS_WIDTH'(I_REF_DELTA_INSTB)) : '0;

    assign drop_hit = ({1'b0, q_measured} + (BUS_WIDTH + 1)'(DELTA_Q_INSTB)) < {1'b0, prev_q};
    assign unstable = last_raised && drop_hit;

    generate
        if (INCLUDE_Q_DROP != 0) begin : g_q_drop
            logic [BUS_WIDTH-1:0] ceiling_r;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    prev_q      <= '0;
                    last_raised <= 1'b0;
                    ceiling_r   <= '1;
                end else if (do_update) begin
                    prev_q      <= q_measured;
                    last_raised <= !unstable && !in_tol && !err[EW-1] && (up_val > i_ref);
                    if (unstable) begin
                        ceiling_r <= backoff_val;
                    end
                end
            end

            assign ceiling = ceiling_r;
        end else begin : g_no_q_drop
            assign prev_q      = '0;
            assign last_raised = 1'b0;
            assign ceiling     = '1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            i_ref     <= '0;
            converged <= 1'b0;
        end else if (do_update) begin
            if (unstable) begin
                i_ref     <= backoff_val;
                converged <= 1'b0;
            end else if (in_tol) begin
                converged <= 1'b1;
            end else begin
                converged <= 1'b0;
                i_ref     <= err[EW-1] ? down_val : up_val;
            end
        end
    end

endmodule

// File: rtl/top.sv
// Q-seek front-end: synchronizes and counts the Q pulse train, closes each train with a
// watchdog timeout, and feeds the measurement to q_control. Define TOP_DEBUG_PORTS_EN for debug outputs.
module top
    import top_pkg::*;
#(
    parameter int BUS_WIDTH         = DEF_BUS_WIDTH,
    parameter int WTD_BUS_WIDTH     = DEF_WTD_BUS_WIDTH,
    parameter int Q_PER_PULSE       = DEF_Q_PER_PULSE,
    parameter int TOL               = DEF_TOL,
    parameter int I_REF_DELTA_INSTB = DEF_I_REF_DELTA_INSTB,
    parameter int DELTA_Q_INSTB     = DEF_DELTA_Q_INSTB,
    parameter int INCLUDE_Q_DROP    = DEF_INCLUDE_Q_DROP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 q_serialized,
    input  logic                 start,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] q_desired,
`ifdef TOP_DEBUG_PORTS_EN
    output logic [BUS_WIDTH-1:0] q_measured_out,
    output logic                 ready_out,
    output logic                 converged_out,
`endif
    output logic [BUS_WIDTH-1:0] i_ref_out
);

    localparam logic [BUS_WIDTH:0]       Q_INC    = (BUS_WIDTH + 1)'(Q_PER_PULSE);
    localparam logic [BUS_WIDTH-1:0]     Q_MAX    = '1;
    localparam logic [WTD_BUS_WIDTH-1:0] WTD_LAST = WTD_BUS_WIDTH'(2 ** WTD_BUS_WIDTH - 2);

    logic                     q_sync1, q_sync2, q_sync_d;
    logic                     q_edge;
    logic [BUS_WIDTH-1:0]     acc;
    logic [BUS_WIDTH:0]       acc_sum;
    logic [WTD_BUS_WIDTH-1:0] wtd;
    logic                     wtd_run;
    logic                     wtd_expire;
    logic [BUS_WIDTH-1:0]     q_measured_w;
    logic                     ready_w;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_sync1  <= 1'b0;
            q_sync2  <= 1'b0;
            q_sync_d <= 1'b0;
        end else begin
            q_sync1  <= q_serialized;
            q_sync2  <= q_sync1;
            q_sync_d <= q_sync2;
        end
    end

    assign q_edge  = q_sync2 && !q_sync_d;
    assign acc_sum = {1'b0, acc} + Q_INC;

    // Expiring one count early makes the hand-off land exactly when the watchdog would read all-ones
    assign wtd_expire = wtd_run && !q_edge && (wtd == WTD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc          <= '0;
            wtd          <= '0;
            wtd_run      <= 1'b0;
            q_measured_w <= '0;
            ready_w      <= 1'b0;
        end else begin
            ready_w <= 1'b0;
            if (!start) begin
                acc     <= '0;
                wtd     <= '0;
                wtd_run <= 1'b0;
            end else if (q_edge) begin
                acc     <= acc_sum[BUS_WIDTH] ? Q_MAX : acc_sum[BUS_WIDTH-1:0];
                wtd     <= '0;
                wtd_run <= 1'b1;
            end else if (wtd_expire) begin
                q_measured_w <= acc;
                ready_w      <= 1'b1;
                acc          <= '0;
                wtd          <= '0;
                wtd_run      <= 1'b0;
            end else if (wtd_run) begin
                wtd <= wtd + 1'b1;
            end
        end
    end

`ifdef TOP_DEBUG_PORTS_EN
    logic converged;
    assign q_measured_out = q_measured_w;
    assign ready_out      = ready_w;
    assign converged_out  = converged;
`else
    logic converged_unused;
`endif

    q_control #(
        .BUS_WIDTH        (BUS_WIDTH),
        .TOL              (TOL),
        .I_REF_DELTA_INSTB(I_REF_DELTA_INSTB),
        .DELTA_Q_INSTB    (DELTA_Q_INSTB),
        .INCLUDE_Q_DROP   (INCLUDE_Q_DROP)
    ) q_control_inst (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .enable    (enable),
        .ready     (ready_w),
        .q_desired (q_desired),
        .q_measured(q_measured_w),
        .i_ref     (i_ref_out),
`ifdef TOP_DEBUG_PORTS_EN
        .converged (converged)
`else
        .converged (converged_unused)
`endif
    );

endmodule

// File: tb/tb_top.sv
// Randomized bench for the Q-seek controller, checked against a transaction-level model
// of the measurement and control rules (instance built with the Q-drop detector enabled).
module tb_top;

    localparam int BW    = 10;
    localparam int Q_CAP = 1023;
    localparam int LAT   = (2 ** 3 - 1) + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          q_serialized;
    logic          start;
    logic          enable;
    logic [BW-1:0] q_desired;
    logic [BW-1:0] i_ref_out;
`ifdef TOP_DEBUG_PORTS_EN
    logic [BW-1:0] q_measured_out;
    logic          ready_out;
    logic          converged_out;
`endif

    int total = 0;
    int bad   = 0;
    int ready_seen = 0;

    int m_iref, m_prev_q, m_ceiling;
    bit m_raised, m_conv;

    always #5 clk = ~clk;

    top #(.INCLUDE_Q_DROP(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .q_serialized  (q_serialized),
        .start         (start),
        .enable        (enable),
        .q_desired     (q_desired),
`ifdef TOP_DEBUG_PORTS_EN
        .q_measured_out(q_measured_out),
        .ready_out     (ready_out),
        .converged_out (converged_out),
`endif
        .i_ref_out     (i_ref_out)
    );

    always @(negedge clk) begin
        if (dut.ready_w === 1'b1) ready_seen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_iref    = 0;
        m_prev_q  = 0;
        m_ceiling = Q_CAP;
        m_raised  = 1'b0;
        m_conv    = 1'b0;
    endtask

    // One completed measurement as seen by the control loop
    task automatic modelMeasurement(input int q, input bit en, input int qd);
        int err, mag, step, nxt;
        if (!en) return;
        err = qd - q;
        mag = (err < 0) ? -err : err;
        if (m_raised && (q + 50 < m_prev_q)) begin
            m_iref    = (m_iref > 10) ? m_iref - 10 : 0;
            m_ceiling = m_iref;
            m_conv    = 1'b0;
            m_raised  = 1'b0;
        end else if (mag <= 6) begin
            m_conv   = 1'b1;
            m_raised = 1'b0;
        end else begin
            step   = (mag / 4 < 1) ? 1 : mag / 4;
            m_conv = 1'b0;
            if (err > 0) begin
                nxt      = (m_iref + step > m_ceiling) ? m_ceiling : m_iref + step;
                m_raised = (nxt > m_iref);
                m_iref   = nxt;
            end else begin
                m_iref   = (m_iref > step) ? m_iref - step : 0;
                m_raised = 1'b0;
            end
        end
        m_prev_q = q;
    endtask

    task automatic doReset();
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        modelReset();
    endtask

    // Sends a train; latency counts clocks from the edge that first samples the last pulse
    task automatic applyStimulus(input int n_pulses, output int latency);
        for (int i = 0; i < n_pulses - 1; i++) begin
            @(negedge clk) q_serialized = 1'b1;
            @(negedge clk) q_serialized = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        @(negedge clk) q_serialized = 1'b1;
        latency = 0;
        do begin
            @(posedge clk);
            #1;
            latency++;
            if (latency == 1) q_serialized = 1'b0;
        end while (dut.ready_w !== 1'b1 && latency < 40);
        latency = latency - 1;
    endtask

    task automatic doMeasurement(input int n_pulses, input bit en, input int qd);
        int lat, seen0, exp_q;
        @(negedge clk);
        enable    = en;
        q_desired = qd[BW-1:0];
        repeat (2) @(negedge clk);
        seen0 = ready_seen;
        applyStimulus(n_pulses, lat);
        repeat (3) @(negedge clk);
        exp_q = (3 * n_pulses > Q_CAP) ? Q_CAP : 3 * n_pulses;
        modelMeasurement(exp_q, en, qd);
        checkOutput("latency", lat, LAT);
        checkOutput("ready_pulses", ready_seen - seen0, 1);
        checkOutput("q_measured", dut.q_measured_w, exp_q);
        checkOutput("i_ref", i_ref_out, m_iref);
        checkOutput("converged", dut.q_control_inst.converged, m_conv);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL global_timeout: observed=expired expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int n, qd, lo, hi, frozen;
        int lo_tab[4] = '{40, 60, 100, 140};
        int hi_tab[4] = '{60, 100, 140, 260};

        rst          = 1'b0;
        start        = 1'b0;
        enable       = 1'b0;
        q_serialized = 1'b0;
        q_desired    = '0;
        modelReset();

        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_i_ref", i_ref_out, 0);
        checkOutput("rst_ready", dut.ready_w, 0);
        checkOutput("rst_converged", dut.q_control_inst.converged, 0);
        checkOutput("rst_q_measured", dut.q_measured_w, 0);
        rst = 1'b1;

        // First transaction from the worked example: 4 pulses, target 60
        start = 1'b1;
        doMeasurement(4, 1'b1, 60);
        checkOutput("first_i_ref", i_ref_out, 12);

        // Downward step from zero must floor at zero
        doReset();
        doMeasurement(10, 1'b1, 0);
        checkOutput("floor_i_ref", i_ref_out, 0);

        // Reset in the middle of a train discards the partial count
        doReset();
        @(negedge clk) enable = 1'b1;
        q_desired = 10'd60;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk) q_serialized = 1'b1;
            @(negedge clk) q_serialized = 1'b0;
        end
        doReset();
        doMeasurement(2, 1'b1, 60);

        // Accumulator saturation with the loop frozen
        frozen = i_ref_out;
        doMeasurement(345, 1'b0, 500);
        checkOutput("sat_frozen_i_ref", i_ref_out, frozen);

        // Q collapse right after a raise to 200
        doReset();
        doMeasurement(40, 1'b1, 920);
        checkOutput("pre_drop_i_ref", i_ref_out, 200);
        doMeasurement(20, 1'b1, 920);
        checkOutput("backoff_i_ref", i_ref_out, 190);
        for (int k = 0; k < 3; k++) begin
            doMeasurement(5 + k, 1'b1, 920);
            checkOutput("ceiling_held", (i_ref_out > 10'd190), 0);
        end

        // Randomized trains, targets and enable
        doReset();
        for (int t = 0; t < 30; t++) begin
            n  = $urandom_range(1, 60);
            qd = $urandom_range(0, 300);
            doMeasurement(n, ($urandom_range(0, 3) != 0), qd);
        end

        // Closed loop against a plant whose Q tracks i_ref
        for (int r = 0; r < 4; r++) begin
            doReset();
            lo = lo_tab[r];
            hi = hi_tab[r];
            qd = $urandom_range(lo, hi);
            for (int it = 0; it < 60; it++) begin
                n = (int'(i_ref_out) + 1) / 3;
                if (n < 1) n = 1;
                doMeasurement(n, 1'b1, qd);
                if (dut.q_control_inst.converged === 1'b1) break;
            end
            checkOutput("loop_converged", dut.q_control_inst.converged, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
